// File: rtl/lives_pkg.sv
// Shared types and default geometry for the life-icon bar.
package lives_pkg;

    localparam int LIVES_W = 3;
    localparam int COORD_W = 11;

    localparam int DEF_TOP_LEFT_X   = 16;
    localparam int DEF_TOP_LEFT_Y   = 8;
    localparam int DEF_ICON_W       = 25;
    localparam int DEF_ICON_H       = 25;
    localparam int DEF_ICON_GAP     = 4;
    localparam int DEF_MAX_LIVES    = 5;
    localparam int DEF_INIT_LIVES   = 3;
    localparam int DEF_BLINK_FRAMES = 60;
    localparam int DEF_BLINK_PERIOD = 8;

    typedef enum logic [1:0] {
        ST_PLAYING   = 2'd0,
        ST_GRACE     = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

endpackage

// File: rtl/lives_fsm.sv
// Lives counter, post-hit grace timer and blink phase.
// With LIVES_LAST_LIFE_FLASH_EN the phase also free-runs in PLAYING.
module lives_fsm
    import lives_pkg::*;
#(
    parameter int MAX_LIVES    = DEF_MAX_LIVES,
    parameter int INIT_LIVES   = DEF_INIT_LIVES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int BLINK_PERIOD = DEF_BLINK_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               lifeLost,
    input  logic               lifeGained,
    input  logic               newGame,
    output logic [LIVES_W-1:0] livesCount,
    output state_t             state,
    output logic               phase,
    output logic               gameOver
);

    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam int PH_W  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [LIVES_W-1:0] r_lives;
    state_t             r_state;
    logic [BLK_W-1:0]   r_blink_cnt;
    logic [PH_W-1:0]    r_phase_cnt;
    logic               r_phase;
    logic               r_game_over;

    logic               w_lost_only;
    logic               w_gain_only;
    logic               w_phase_wrap;
    logic [PH_W-1:0]    w_phase_cnt_nxt;
    logic               w_phase_nxt;
    logic [LIVES_W-1:0] w_lives_inc;

    assign w_lost_only     = lifeLost & ~lifeGained;
    assign w_gain_only     = lifeGained & ~lifeLost;
    assign w_phase_wrap    = (r_phase_cnt == PH_W'(BLINK_PERIOD - 1));
    assign w_phase_cnt_nxt = w_phase_wrap ? '0 : r_phase_cnt + PH_W'(1);
    assign w_phase_nxt     = r_phase ^ w_phase_wrap;
    assign w_lives_inc     = (r_lives < LIVES_W'(MAX_LIVES)) ? r_lives + LIVES_W'(1) : r_lives;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lives     <= LIVES_W'(INIT_LIVES);
            r_state     <= ST_PLAYING;
            r_blink_cnt <= '0;
            r_phase_cnt <= '0;
            r_phase     <= 1'b0;
            r_game_over <= 1'b0;
        end else if (newGame) begin
            r_lives     <= LIVES_W'(INIT_LIVES);
            r_state     <= ST_PLAYING;
            r_blink_cnt <= '0;
            r_phase_cnt <= '0;
            r_phase     <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_PLAYING: begin
`ifdef LIVES_LAST_LIFE_FLASH_EN
                    if (startOfFrame) begin
                        r_phase_cnt <= w_phase_cnt_nxt;
                        r_phase     <= w_phase_nxt;
                    end
`endif
                    // Hit handling is placed last so it overrides the free-running phase.
                    if (w_lost_only) begin
                        if (r_lives > LIVES_W'(1)) begin
                            r_lives     <= r_lives - LIVES_W'(1);
                            r_state     <= ST_GRACE;
                            r_blink_cnt <= BLK_W'(BLINK_FRAMES);
                            r_phase_cnt <= '0;
                            r_phase     <= 1'b0;
                        end else begin
                            r_lives     <= '0;
                            r_state     <= ST_GAME_OVER;
                            r_game_over <= 1'b1;
                        end
                    end else if (w_gain_only) begin
                        r_lives <= w_lives_inc;
                    end
                end
                ST_GRACE: begin
                    if (w_gain_only) begin
                        r_lives <= w_lives_inc;
                    end
                    if (startOfFrame) begin
                        if (r_blink_cnt <= BLK_W'(1)) begin
                            r_blink_cnt <= '0;
                            r_state     <= ST_PLAYING;
                            r_phase_cnt <= '0;
                            r_phase     <= 1'b0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt - BLK_W'(1);
                            r_phase_cnt <= w_phase_cnt_nxt;
                            r_phase     <= w_phase_nxt;
                        end
                    end
                end
                ST_GAME_OVER: begin
                end
                default: r_state <= ST_PLAYING;
            endcase
        end
    end

    assign livesCount = r_lives;
    assign state      = r_state;
    assign phase      = r_phase;
    assign gameOver   = r_game_over;

endmodule

// File: rtl/lives_bar.sv
// Life-icon bar: maps the scan pixel onto visible icon slots and registers the offsets.
// Optional LIVES_LAST_LIFE_FLASH_EN blinks slot 0 while on the last life.
module lives_bar
    import lives_pkg::*;
#(
    parameter int TOP_LEFT_X   = DEF_TOP_LEFT_X,
    parameter int TOP_LEFT_Y   = DEF_TOP_LEFT_Y,
    parameter int ICON_W       = DEF_ICON_W,
    parameter int ICON_H       = DEF_ICON_H,
    parameter int ICON_GAP     = DEF_ICON_GAP,
    parameter int MAX_LIVES    = DEF_MAX_LIVES,
    parameter int INIT_LIVES   = DEF_INIT_LIVES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int BLINK_PERIOD = DEF_BLINK_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               lifeLost,
    input  logic               lifeGained,
    input  logic               newGame,
    output logic [COORD_W-1:0] offsetX,
    output logic [COORD_W-1:0] offsetY,
    output logic               InsideRectangle,
    output logic [LIVES_W-1:0] livesCount,
    output logic               gameOver
);

    localparam logic [COORD_W-1:0] Y_TOP = COORD_W'(TOP_LEFT_Y);
    localparam logic [COORD_W-1:0] Y_BOT = COORD_W'(TOP_LEFT_Y + ICON_H - 1);

    logic [LIVES_W-1:0] w_lives;
    state_t             w_state;
    logic               w_phase;
    logic               w_in_y;
    logic               w_dim_slot0;
    logic [MAX_LIVES-1:0] w_hit;
    logic [COORD_W-1:0] w_offx [MAX_LIVES];
    logic [COORD_W-1:0] w_offx_sel;

    logic [COORD_W-1:0] r_offset_x;
    logic [COORD_W-1:0] r_offset_y;
    logic               r_inside;

    lives_fsm #(
        .MAX_LIVES    (MAX_LIVES),
        .INIT_LIVES   (INIT_LIVES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .lifeLost     (lifeLost),
        .lifeGained   (lifeGained),
        .newGame      (newGame),
        .livesCount   (w_lives),
        .state        (w_state),
        .phase        (w_phase),
        .gameOver     (gameOver)
    );

    assign livesCount = w_lives;
    assign w_in_y     = (pixelY >= Y_TOP) && (pixelY <= Y_BOT);

`ifdef LIVES_LAST_LIFE_FLASH_EN
    assign w_dim_slot0 = (w_state == ST_PLAYING) && (w_lives == LIVES_W'(1)) && !w_phase;
`else
    assign w_dim_slot0 = 1'b0;
`endif

    // Slot edges are elaboration-time constants; only compares remain in hardware.
    for (genvar i = 0; i < MAX_LIVES; i++) begin : g_slot
        localparam logic [COORD_W-1:0] X_L = COORD_W'(TOP_LEFT_X + i * (ICON_W + ICON_GAP));
        localparam logic [COORD_W-1:0] X_R = COORD_W'(TOP_LEFT_X + i * (ICON_W + ICON_GAP) + ICON_W - 1);
        logic w_vis;
        assign w_vis = ((LIVES_W'(i) < w_lives) ||
                        ((w_state == ST_GRACE) && (LIVES_W'(i) == w_lives) && w_phase)) &&
                       !((i == 0) && w_dim_slot0);
        assign w_hit[i]  = w_vis && w_in_y && (pixelX >= X_L) && (pixelX <= X_R);
        assign w_offx[i] = w_hit[i] ? (pixelX - X_L) : '0;
    end

    always_comb begin
        w_offx_sel = '0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            w_offx_sel = w_offx_sel | w_offx[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inside   <= 1'b0;
            r_offset_x <= '0;
            r_offset_y <= '0;
        end else begin
            r_inside   <= |w_hit;
            r_offset_x <= w_offx_sel;
            r_offset_y <= (|w_hit) ? (pixelY - Y_TOP) : '0;
        end
    end

    assign InsideRectangle = r_inside;
    assign offsetX         = r_offset_x;
    assign offsetY         = r_offset_y;

endmodule
